rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Shares one unified memory port between the rv32i_core instruction-fetch unit (IF) and load/store unit (LSU). Fixed priority to LSU, with a starvation guard for IF. One outstanding transaction at a time. Sits between the core's IF/LSU request interfaces and the single memory model instantiated beside rv32i_core.

Parameters:
ADDR_W, 32, address width of all request ports
DATA_W, 32, data width of all read/write data ports
STARVE_MAX, 4, consecutive LSU grants with IF waiting before IF is forced a grant

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req_valid  in  1  IF read request pending
if_req_addr  in  ADDR_W  IF fetch address
if_req_ready  out  1  IF request accepted this cycle
if_resp_valid  out  1  IF read data valid (1-cycle pulse)
if_resp_rdata  out  DATA_W  IF read data
ls_req_valid  in  1  LSU request pending
ls_req_we  in  1  1=store, 0=load
ls_req_addr  in  ADDR_W  LSU address
ls_req_wdata  in  DATA_W  store data
ls_req_wstrb  in  DATA_W/8  store byte enables
ls_req_ready  out  1  LSU request accepted this cycle
ls_resp_valid  out  1  LSU load data / store ack (1-cycle pulse)
ls_resp_rdata  out  DATA_W  LSU load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  write enable
mem_req_addr  out  ADDR_W  address
mem_req_wdata  out  DATA_W  write data
mem_req_wstrb  out  DATA_W/8  byte enables
mem_resp_valid  in  1  memory response valid
mem_resp_rdata  in  DATA_W  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Single clock clk; reset rst synchronous, active-high. On reset: state=IDLE, owner=IF, starve_cnt=0, latched request regs=0. All outputs 0: mem_req_*, *_req_ready, *_resp_valid, *_resp_rdata, busy.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational):
  - grant_if = if_req_valid & (~ls_req_valid | starve_cnt==STARVE_MAX).
  - grant_ls = ls_req_valid & ~grant_if.
  - if_req_ready=grant_if and ls_req_ready=grant_ls, only in IDLE. Both readies are 0 in every other state.
- On a grant, the winner's fields are latched at the clock edge. IF grants latch we=0, wstrb=0, wdata=0. Owner is recorded. Next state is ISSUE.
- Requesters hold valid and fields stable until ready. Arbiter never drops an accepted request.
- ISSUE: mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1. Then go to WAIT. mem_resp_valid is ignored in ISSUE.
- WAIT: mem_req_valid=0.
  - When mem_resp_valid=1, the owner's resp_valid=1 and resp_rdata=mem_resp_rdata, combinationally in that same cycle. Next state is IDLE.
  - The non-owner's resp_valid stays 0 and its rdata holds 0.
  - Stores also receive a resp_valid ack; rdata on a store ack is don't-care.
- Minimum round trip: accept at N, memory handshake at N+1, response at N+2, next accept at N+3.
- Starvation counter:
  - LSU grant while if_req_valid=1: starve_cnt increments, saturating at STARVE_MAX.
  - IF grant: starve_cnt clears to 0.
  - LSU grant with IF idle: starve_cnt unchanged.
- Simultaneous requests with starve_cnt<STARVE_MAX: LSU wins.
- mem_resp_valid in IDLE or ISSUE is ignored and not forwarded.
- Reset mid-transaction (ISSUE or WAIT): on the next edge, return to IDLE with mem_req_valid=0. A late mem_resp_valid is then ignored.
- busy=1 in ISSUE and WAIT.

Test Plan:
- IF read alone: if_req_addr=0x0000_0010, mem_req_ready=1, memory returns 0x0010_0093 one cycle later. Required: if_req_ready pulses at N, mem_req_valid/addr=0x10/we=0 at N+1, if_resp_valid=1 with rdata=0x0010_0093 at N+2, ls_resp_valid stays 0.
- Simultaneous IF and LSU store: LSU addr=0x100, wdata=0xDEAD_BEEF, wstrb=0xF. Required: ls_req_ready first, mem_req_we=1 with those fields, ls_resp_valid ack; IF is granted in the next IDLE.
- Memory backpressure: mem_req_ready low for 3 cycles in ISSUE. Required: mem_req_valid, addr, wdata and wstrb held constant all 3 cycles, busy=1, both readies 0.
- Starvation: IF and LSU continuously valid, STARVE_MAX=4. Required: 4 LSU grants, then an IF grant, with starve_cnt returning to 0; the pattern repeats.
- Spurious response: mem_resp_valid=1 while in IDLE and in ISSUE. Required: no resp_valid on either requester, state unchanged.
- Reset mid-WAIT: assert rst for 1 cycle, then memory raises mem_resp_valid. Required: busy=0 and mem_req_valid=0 after the edge; no resp_valid pulses; the next request is arbitrated normally.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Handshake/bus bundle for rv32i_mem_arbiter.
//   IF side  : if_req_valid/addr/ready, if_resp_valid/rdata
//   LSU side : ls_req_valid/we/addr/wdata/wstrb/ready, ls_resp_valid/rdata
//   Memory   : mem_req_valid/ready/we/addr/wdata/wstrb, mem_resp_valid/rdata
// modport slave  : the arbiter's view.
// modport master : the environment's view (requesters plus memory model).
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_rdata;

  logic                ls_req_valid;
  logic                ls_req_we;
  logic [ADDR_W-1:0]   ls_req_addr;
  logic [DATA_W-1:0]   ls_req_wdata;
  logic [DATA_W/8-1:0] ls_req_wstrb;
  logic                ls_req_ready;
  logic                ls_resp_valid;
  logic [DATA_W-1:0]   ls_resp_rdata;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wstrb;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_rdata,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wstrb,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_rdata,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wstrb,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between the instruction-fetch unit (IF) and the
// load/store unit (LSU). LSU has fixed priority; IF is forced a grant after
// STARVE_MAX consecutive LSU grants taken while IF was waiting. One
// transaction in flight at a time.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - request/response/memory handshake bundle (slave modport)
//   busy - transaction in flight (ISSUE or WAIT)
//
// state | meaning
// IDLE  | arbitrate; winner's fields latched on the grant edge
// ISSUE | mem_req_valid held with latched fields until mem_req_ready
// WAIT  | waiting for mem_resp_valid, forwarded to the owner
module rv32i_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  rv32i_mem_arbiter_if.slave        bus,
  output logic                      busy
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state_q;
  logic                owner_ls_q;
  logic [CNT_W-1:0]    starve_q;
  logic                mem_valid_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic in_idle;
  logic starve_hit;
  logic grant_if;
  logic grant_ls;
  logic resp_fire;

  // Readies and responses are combinational; gating with rst keeps every
  // output quiet while reset is held.
  always_comb begin
    in_idle    = (state_q == S_IDLE) && !rst;
    starve_hit = (starve_q == CNT_W'(STARVE_MAX));
    grant_if   = in_idle && bus.if_req_valid && (!bus.ls_req_valid || starve_hit);
    grant_ls   = in_idle && bus.ls_req_valid && !grant_if;
    resp_fire  = (state_q == S_WAIT) && bus.mem_resp_valid && !rst;
  end

  assign bus.if_req_ready  = grant_if;
  assign bus.ls_req_ready  = grant_ls;
  assign bus.if_resp_valid = resp_fire && !owner_ls_q;
  assign bus.ls_resp_valid = resp_fire && owner_ls_q;
  assign bus.if_resp_rdata = (resp_fire && !owner_ls_q) ? bus.mem_resp_rdata : '0;
  assign bus.ls_resp_rdata = (resp_fire && owner_ls_q)  ? bus.mem_resp_rdata : '0;

  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wstrb = wstrb_q;
  assign busy              = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_ls_q  <= 1'b0;
      starve_q    <= '0;
      mem_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_if) begin
            owner_ls_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= bus.if_req_addr;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            starve_q    <= '0;
            mem_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else if (grant_ls) begin
            owner_ls_q  <= 1'b1;
            we_q        <= bus.ls_req_we;
            addr_q      <= bus.ls_req_addr;
            wdata_q     <= bus.ls_req_wdata;
            wstrb_q     <= bus.ls_req_wstrb;
            // only count LSU wins that actually made IF wait
            if (bus.if_req_valid && !starve_hit)
              starve_q <= starve_q + CNT_W'(1);
            mem_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid)
            state_q <= S_IDLE;
        end
        default: begin
          mem_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter. Inputs change and outputs are
// checked in the low phase of the clock (negedge, then #1 to settle).
module tb_rv32i_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_req_we      = 1'b0;
    bus.ls_req_addr    = '0;
    bus.ls_req_wdata   = '0;
    bus.ls_req_wstrb   = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic test_reset();
    tick();
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    #1;
    total++; if (bus.if_req_ready !== 1'b0) begin bad++; $display("FAIL rst_if_ready got=%b exp=0", bus.if_req_ready); end
    total++; if (bus.ls_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ls_ready got=%b exp=0", bus.ls_req_ready); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b exp=0", bus.mem_req_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (bus.mem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_req_addr); end
    tick();
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    tick();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0010;
    #1;
    total++; if (bus.if_req_ready !== 1'b1) begin bad++; $display("FAIL ifrd_ready got=%b exp=1", bus.if_req_ready); end
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL ifrd_mem_valid got=%b exp=1", bus.mem_req_valid); end
    total++; if (bus.mem_req_addr !== 32'h10) begin bad++; $display("FAIL ifrd_mem_addr got=%h exp=10", bus.mem_req_addr); end
    total++; if (bus.mem_req_we !== 1'b0) begin bad++; $display("FAIL ifrd_mem_we got=%b exp=0", bus.mem_req_we); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0010_0093;
    #1;
    total++; if (bus.if_resp_valid !== 1'b1) begin bad++; $display("FAIL ifrd_resp_valid got=%b exp=1", bus.if_resp_valid); end
    total++; if (bus.if_resp_rdata !== 32'h0010_0093) begin bad++; $display("FAIL ifrd_rdata got=%h exp=00100093", bus.if_resp_rdata); end
    total++; if (bus.ls_resp_valid !== 1'b0) begin bad++; $display("FAIL ifrd_ls_resp got=%b exp=0", bus.ls_resp_valid); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL ifrd_wait_mem_valid got=%b exp=0", bus.mem_req_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ifrd_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_simul_store();
    tick();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0020;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b1;
    bus.ls_req_addr  = 32'h0000_0100;
    bus.ls_req_wdata = 32'hDEAD_BEEF;
    bus.ls_req_wstrb = 4'hF;
    #1;
    total++; if (bus.ls_req_ready !== 1'b1) begin bad++; $display("FAIL sim_ls_ready got=%b exp=1", bus.ls_req_ready); end
    total++; if (bus.if_req_ready !== 1'b0) begin bad++; $display("FAIL sim_if_ready got=%b exp=0", bus.if_req_ready); end
    tick();
    bus.ls_req_valid = 1'b0;
    #1;
    total++; if (bus.mem_req_we !== 1'b1) begin bad++; $display("FAIL sim_mem_we got=%b exp=1", bus.mem_req_we); end
    total++; if (bus.mem_req_addr !== 32'h100) begin bad++; $display("FAIL sim_mem_addr got=%h exp=100", bus.mem_req_addr); end
    total++; if (bus.mem_req_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sim_mem_wdata got=%h exp=deadbeef", bus.mem_req_wdata); end
    total++; if (bus.mem_req_wstrb !== 4'hF) begin bad++; $display("FAIL sim_mem_wstrb got=%h exp=f", bus.mem_req_wstrb); end
    total++; if (bus.if_req_ready !== 1'b0) begin bad++; $display("FAIL sim_issue_if_ready got=%b exp=0", bus.if_req_ready); end
    tick();
    bus.mem_resp_valid = 1'b1;
    #1;
    total++; if (bus.ls_resp_valid !== 1'b1) begin bad++; $display("FAIL sim_ls_ack got=%b exp=1", bus.ls_resp_valid); end
    total++; if (bus.if_resp_valid !== 1'b0) begin bad++; $display("FAIL sim_if_resp got=%b exp=0", bus.if_resp_valid); end
    total++; if (bus.if_resp_rdata !== 32'h0) begin bad++; $display("FAIL sim_if_rdata got=%h exp=0", bus.if_resp_rdata); end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    total++; if (bus.if_req_ready !== 1'b1) begin bad++; $display("FAIL sim_if_next got=%b exp=1", bus.if_req_ready); end
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    total++; if (bus.mem_req_addr !== 32'h20) begin bad++; $display("FAIL sim_if_addr got=%h exp=20", bus.mem_req_addr); end
    total++; if (bus.mem_req_we !== 1'b0) begin bad++; $display("FAIL sim_if_we got=%b exp=0", bus.mem_req_we); end
    total++; if (bus.mem_req_wstrb !== 4'h0) begin bad++; $display("FAIL sim_if_wstrb got=%h exp=0", bus.mem_req_wstrb); end
    total++; if (bus.mem_req_wdata !== 32'h0) begin bad++; $display("FAIL sim_if_wdata got=%h exp=0", bus.mem_req_wdata); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1234_0000;
    #1;
    total++; if (bus.if_resp_valid !== 1'b1) begin bad++; $display("FAIL sim_if_resp2 got=%b exp=1", bus.if_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    tick();
    bus.ls_req_valid  = 1'b1;
    bus.ls_req_we     = 1'b1;
    bus.ls_req_addr   = 32'h0000_0200;
    bus.ls_req_wdata  = 32'h1234_5678;
    bus.ls_req_wstrb  = 4'h3;
    bus.mem_req_ready = 1'b0;
    #1;
    total++; if (bus.ls_req_ready !== 1'b1) begin bad++; $display("FAIL bp_ls_ready got=%b exp=1", bus.ls_req_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.ls_req_valid = 1'b1;
      bus.ls_req_addr  = 32'h0000_0300 + c;
      bus.if_req_valid = 1'b1;
      #1;
      total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.mem_req_valid); end
      total++; if (bus.mem_req_addr !== 32'h200) begin bad++; $display("FAIL bp_addr c=%0d got=%h exp=200", c, bus.mem_req_addr); end
      total++; if (bus.mem_req_wdata !== 32'h1234_5678) begin bad++; $display("FAIL bp_wdata c=%0d got=%h exp=12345678", c, bus.mem_req_wdata); end
      total++; if (bus.mem_req_wstrb !== 4'h3) begin bad++; $display("FAIL bp_wstrb c=%0d got=%h exp=3", c, bus.mem_req_wstrb); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, busy); end
      total++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b00) begin bad++; $display("FAIL bp_readies c=%0d got=%b exp=00", c, {bus.if_req_ready, bus.ls_req_ready}); end
    end
    tick();
    bus.ls_req_valid  = 1'b0;
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_handshake got=%b exp=1", bus.mem_req_valid); end
    tick();
    bus.mem_resp_valid = 1'b1;
    #1;
    total++; if (bus.ls_resp_valid !== 1'b1) begin bad++; $display("FAIL bp_ack got=%b exp=1", bus.ls_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_starvation();
    // grant sequence with both always valid, starve count starting at 0
    logic exp_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bus.ls_req_we   = 1'b0;
    bus.ls_req_addr = 32'h0000_0300;
    bus.if_req_addr = 32'h0000_0400;
    for (int g = 0; g < 10; g++) begin
      tick();
      bus.if_req_valid = 1'b1;
      bus.ls_req_valid = 1'b1;
      #1;
      total++; if (bus.if_req_ready !== exp_if[g]) begin bad++; $display("FAIL stv_if_ready g=%0d got=%b exp=%b", g, bus.if_req_ready, exp_if[g]); end
      total++; if (bus.ls_req_ready !== !exp_if[g]) begin bad++; $display("FAIL stv_ls_ready g=%0d got=%b exp=%b", g, bus.ls_req_ready, !exp_if[g]); end
      tick();
      #1;
      total++; if (bus.mem_req_addr !== (exp_if[g] ? 32'h400 : 32'h300)) begin bad++; $display("FAIL stv_addr g=%0d got=%h", g, bus.mem_req_addr); end
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 32'hA0 + g;
      #1;
      if (exp_if[g]) begin
        total++; if (bus.if_resp_rdata !== 32'hA0 + g) begin bad++; $display("FAIL stv_if_rdata g=%0d got=%h", g, bus.if_resp_rdata); end
      end else begin
        total++; if (bus.ls_resp_rdata !== 32'hA0 + g) begin bad++; $display("FAIL stv_ls_rdata g=%0d got=%h", g, bus.ls_resp_rdata); end
      end
      total++; if ({bus.if_resp_valid, bus.ls_resp_valid} !== {exp_if[g], !exp_if[g]}) begin bad++; $display("FAIL stv_resp g=%0d got=%b", g, {bus.if_resp_valid, bus.ls_resp_valid}); end
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.if_req_valid   = 1'b0;
      bus.ls_req_valid   = 1'b0;
    end
  endtask

  task automatic test_spurious();
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if ({bus.if_resp_valid, bus.ls_resp_valid} !== 2'b00) begin bad++; $display("FAIL spur_idle_resp got=%b exp=00", {bus.if_resp_valid, bus.ls_resp_valid}); end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL spur_idle_state got=%b exp=0", busy); end
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h0000_0040;
    bus.mem_req_ready = 1'b0;
    tick();
    bus.if_req_valid   = 1'b0;
    bus.mem_resp_valid = 1'b1;
    #1;
    total++; if ({bus.if_resp_valid, bus.ls_resp_valid} !== 2'b00) begin bad++; $display("FAIL spur_issue_resp got=%b exp=00", {bus.if_resp_valid, bus.ls_resp_valid}); end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL spur_issue_state got=%b exp=1", bus.mem_req_valid); end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0000_0777;
    #1;
    total++; if (bus.if_resp_rdata !== 32'h777) begin bad++; $display("FAIL spur_real_rdata got=%h exp=777", bus.if_resp_rdata); end
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    tick();
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b0;
    bus.ls_req_addr  = 32'h0000_0500;
    tick();
    bus.ls_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmw_in_wait got=%b exp=1", busy); end
    tick();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h5555_5555;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%b exp=0", busy); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rmw_mem_valid got=%b exp=0", bus.mem_req_valid); end
    total++; if ({bus.if_resp_valid, bus.ls_resp_valid} !== 2'b00) begin bad++; $display("FAIL rmw_resp got=%b exp=00", {bus.if_resp_valid, bus.ls_resp_valid}); end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid   = 1'b1;
    bus.if_req_addr    = 32'h0000_0600;
    #1;
    total++; if (bus.if_req_ready !== 1'b1) begin bad++; $display("FAIL rmw_next_ready got=%b exp=1", bus.if_req_ready); end
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    total++; if (bus.mem_req_addr !== 32'h600) begin bad++; $display("FAIL rmw_next_addr got=%h exp=600", bus.mem_req_addr); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0000_6666;
    #1;
    total++; if (bus.if_resp_valid !== 1'b1) begin bad++; $display("FAIL rmw_next_resp got=%b exp=1", bus.if_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_if_read();
    test_simul_store();
    test_backpressure();
    test_starvation();
    test_spurious();
    test_reset_mid_wait();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
